uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  Frame sequencer for the UART transmitter. Accepts one parallel word per Data_Valid and
//  pulses the parity calculator's load strobe. Then shifts out start, data (LSB first),
//  optional parity and stop bits on TX_OUT, one bit per clock (clock = bit clock).
//  Sits between the host-side data interface and the serial line.
//  Owns the parity calculator's load timing and the output bit multiplexing.
// PARAMETERS
//  DATA_WIDTH  8  width of P_DATA and number of data bits per frame (>=2)
// PORTS
//  Parity_Calc_CLK  in   1           bit clock; all state updates on rising edge
//  Parity_Calc_RST  in   1           reset, asynchronous, active-low
//  P_DATA           in   DATA_WIDTH  word to transmit; sampled on accept
//  Data_Valid       in   1           request to send P_DATA; single-cycle qualifier
//  PAR_EN           in   1           1 = insert parity bit; sampled on accept
//  par_bit          in   1           parity from calculator; valid from cycle after par_load
//  par_load         out  1           1-cycle strobe to calculator's Data_Valid on accept
//  TX_OUT           out  1           registered serial line, idle high
//  Busy             out  1           registered; high while a frame is on TX_OUT
// BEHAVIOUR
//  - Reset (async, any state, mid-frame included):
//    - state=IDLE, TX_OUT=1, Busy=0, par_load=0, bit counter=0, shift reg=0.
//    - Line returns high immediately; the partial frame is dropped.
//  - Accept condition: Data_Valid=1 and state is IDLE or STOP.
//    - On accept, in the same cycle: par_load=1 (combinational), latch P_DATA into the shift
//      reg and latch PAR_EN.
//    - Data_Valid in START/DATA/PARITY is ignored: no par_load, no latch, frame unaffected.
//  - States (TX_OUT/Busy shown are the registered values during the state):
//    - IDLE   : TX_OUT=1, Busy=0. Accept -> START.
//    - START  : TX_OUT=0, Busy=1 -> DATA; counter=0.
//    - DATA   : TX_OUT=shift[0], Busy=1. Shift right each cycle and increment the counter.
//               After bit DATA_WIDTH-1: -> PARITY if latched PAR_EN, else -> STOP.
//    - PARITY : TX_OUT=par_bit (sampled from the calculator, which is stable), Busy=1 -> STOP.
//    - STOP   : TX_OUT=1, Busy=1. Accept -> START (back-to-back, zero idle gap, Busy stays 1);
//               otherwise -> IDLE.
//  - TX_OUT and Busy are registered from the next-state decode.
//    - The first edge after accept shows the start bit.
//    - Latency, accept to start bit: 1 clock.
//  - Frame length on TX_OUT: 1 + DATA_WIDTH + PAR_EN + 1 clocks (8-bit: 11 with parity,
//    10 without).
//  - Counter width: $clog2(DATA_WIDTH). Compare against DATA_WIDTH-1 with no wrap past it.
//    The counter clears on entering START.
//  - PAR_TYP is not handled here: the calculator samples it directly on par_load.
//  - Illegal state encoding -> IDLE with TX_OUT=1 on the next clock.
// STRUCTURE
//  - Shared package uart_tx_pkg:
//    - state enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding
//    - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1
//  - One sub-module: uart_tx_serializer (DATA_WIDTH shift reg + bit counter).
//    - Ports load, shift_en, data_in, ser_bit, ser_done.
//    - Instantiated once; the FSM, bit mux and par_load stay in uart_tx_ctrl.
// TESTING
//  1. P_DATA=8'hA5, PAR_EN=1, even calc, single Data_Valid pulse
//     -> par_load pulses once in the accept cycle.
//     -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 (11 clocks); Busy high for exactly those 11 clocks.
//  2. P_DATA=8'h01, PAR_EN=1, odd calc -> parity slot 0.
//     P_DATA=8'h00, odd -> parity slot 1.
//  3. P_DATA=8'hFF, PAR_EN=0
//     -> TX_OUT = 0, then eight 1s, then stop 1 (10 clocks).
//     -> Busy falls after clock 10; no parity slot.
//  4. Back-to-back: second Data_Valid (8'h3C) asserted in the STOP cycle of frame 8'hA5
//     -> start bit of 8'h3C on the very next clock; Busy never drops; par_load pulses twice total.
//  5. Data_Valid with 8'h77 held during DATA bits 2..5 of frame 8'hA5
//     -> frame bits unchanged; no extra par_load; line idle (1) after stop.
//  6. Parity_Calc_RST low during DATA bit 4
//     -> TX_OUT=1 and Busy=0 asynchronously; after release, IDLE.
//     -> A new 8'h5A frame transmits correctly.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame sequencer states
// and the fixed line levels used for idle, start and stop bits.
package uart_tx_pkg;

    // Frame sequencer states, 3-bit encoding; codes 5..7 are illegal and
    // are recovered to IDLE by the sequencer.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Serial line levels
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data-bit shifter for the UART transmitter. Holds the accepted word and
// counts which data bit is currently on the line.
//
// ser_bit is the bit the sequencer should register onto the line at the
// next edge: before the first data bit (shift_en low) that is bit 0; while
// a data bit is on the line and the register is advancing (shift_en high)
// it is the following bit, which still sits at position 1 this cycle.
// The counter therefore always equals the index of the data bit currently
// on the line, and ser_done flags the last one.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
)
(
    input  logic                  Parity_Calc_CLK,
    input  logic                  Parity_Calc_RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shiftReg;
    logic [CNT_W-1:0]      r_bitCnt;

    // Load the word on accept, then shift right and count once per data bit;
    // the counter holds at the last index instead of wrapping.
    always_ff @(posedge Parity_Calc_CLK or negedge Parity_Calc_RST) begin
        if (!Parity_Calc_RST) begin
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
        end else if (load) begin
            r_shiftReg <= data_in;
            r_bitCnt   <= '0;
        end else if (shift_en) begin
            r_shiftReg <= {1'b0, r_shiftReg[DATA_WIDTH-1:1]};
            if (r_bitCnt != LAST_IDX) begin
                r_bitCnt <= r_bitCnt + CNT_W'(1);
            end
        end
    end

    assign ser_bit  = shift_en ? r_shiftReg[1] : r_shiftReg[0];
    assign ser_done = (r_bitCnt == LAST_IDX);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer. Accepts a parallel word, strobes the
// parity calculator, and drives start, data (LSB first), optional parity
// and stop bits onto TX_OUT at one bit per clock. A new word accepted in
// the stop cycle starts the next frame with no idle gap.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
)
(
    input  logic                  Parity_Calc_CLK,
    input  logic                  Parity_Calc_RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic                  par_load,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_t r_state;
    logic      r_txOut;
    logic      r_busy;
    logic      r_parEn;

    logic      w_accept;
    logic      w_shiftEn;
    logic      w_serBit;
    logic      w_serDone;

    // A word is only taken when the line is idle or finishing a stop bit;
    // requests arriving mid-frame are ignored entirely.
    assign w_accept  = Data_Valid && ((r_state == IDLE) || (r_state == STOP));
    assign w_shiftEn = (r_state == DATA) && !w_serDone;
    assign par_load  = w_accept;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .Parity_Calc_CLK (Parity_Calc_CLK),
        .Parity_Calc_RST (Parity_Calc_RST),
        .load            (w_accept),
        .shift_en        (w_shiftEn),
        .data_in         (P_DATA),
        .ser_bit         (w_serBit),
        .ser_done        (w_serDone)
    );

    // Frame state machine; TX_OUT and Busy are registered from the next
    // state so the line shows the start bit on the first edge after accept.
    always_ff @(posedge Parity_Calc_CLK or negedge Parity_Calc_RST) begin
        if (!Parity_Calc_RST) begin
            r_state <= IDLE;
            r_txOut <= LINE_IDLE;
            r_busy  <= 1'b0;
            r_parEn <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= START;
                        r_txOut <= START_BIT;
                        r_busy  <= 1'b1;
                        r_parEn <= PAR_EN;
                    end else begin
                        r_state <= IDLE;
                        r_txOut <= LINE_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                START: begin
                    r_state <= DATA;
                    r_txOut <= w_serBit;
                    r_busy  <= 1'b1;
                end

                DATA: begin
                    r_busy <= 1'b1;
                    if (w_serDone) begin
                        if (r_parEn) begin
                            r_state <= PARITY;
                            r_txOut <= par_bit;
                        end else begin
                            r_state <= STOP;
                            r_txOut <= STOP_BIT;
                        end
                    end else begin
                        r_state <= DATA;
                        r_txOut <= w_serBit;
                    end
                end

                PARITY: begin
                    r_state <= STOP;
                    r_txOut <= STOP_BIT;
                    r_busy  <= 1'b1;
                end

                STOP: begin
                    if (w_accept) begin
                        r_state <= START;
                        r_txOut <= START_BIT;
                        r_busy  <= 1'b1;
                        r_parEn <= PAR_EN;
                    end else begin
                        r_state <= IDLE;
                        r_txOut <= LINE_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_txOut <= LINE_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = r_txOut;
    assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl. Expected line bits are pushed to a
// scoreboard queue when a word is offered and popped as the line advances.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] pData;
    logic       dataValid;
    logic       parEn;
    logic       parBit;
    logic       parLoad;
    logic       txOut;
    logic       busy;
    logic       parTyp;

    int assertCount;
    int failCount;
    int parLoadCount;

    logic expQ[$];
    logic expBit;

    uart_tx_ctrl #(
        .DATA_WIDTH (8)
    ) dut (
        .Parity_Calc_CLK (clk),
        .Parity_Calc_RST (rst),
        .P_DATA          (pData),
        .Data_Valid      (dataValid),
        .PAR_EN          (parEn),
        .par_bit         (parBit),
        .par_load        (parLoad),
        .TX_OUT          (txOut),
        .Busy            (busy)
    );

    // Bit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Parity calculator stand-in: samples data and parity type on par_load
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            parBit <= 1'b0;
        end else if (parLoad) begin
            parBit <= (^pData) ^ parTyp;
        end
    end

    // Count par_load strobes seen on active edges
    always @(posedge clk) begin
        if (parLoad === 1'b1) begin
            parLoadCount <= parLoadCount + 1;
        end
    end

    function automatic int onesIn(input logic [7:0] d);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) n++;
        end
        return n;
    endfunction

    task automatic pushFrame(input logic [7:0] d, input logic pe, input logic odd);
        int n;
        n = onesIn(d);
        expQ.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            expQ.push_back(d[i]);
        end
        if (pe) begin
            if (odd) expQ.push_back((n % 2) == 0);
            else     expQ.push_back((n % 2) == 1);
        end
        expQ.push_back(1'b1);
    endtask

    // Offer one word for a single cycle; returns 1ns after the accept edge
    task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic odd);
        @(posedge clk);
        #1;
        pData     = d;
        parEn     = pe;
        parTyp    = odd;
        dataValid = 1'b1;
        pushFrame(d, pe, odd);
        @(posedge clk);
        #1;
        dataValid = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        dataValid = 1'b0;
        pData     = 8'h00;
        parEn     = 1'b0;
        parTyp    = 1'b0;
        #2;
        rst = 1'b0;
        #10;
        assertCount++;
        if (txOut !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_tx: TX_OUT=%b expected 1", txOut);
        end
        assertCount++;
        if (busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_busy: Busy=%b expected 0", busy);
        end
        assertCount++;
        if (parLoad !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_par_load: par_load=%b expected 0", parLoad);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        assertCount++;
        if (txOut !== 1'b1 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL post_reset_idle: TX_OUT=%b Busy=%b expected 1/0", txOut, busy);
        end
    endtask

    task automatic test_even_parity;
        int loads0;
        loads0 = parLoadCount;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            expBit = (expQ.size() > 0) ? expQ.pop_front() : 1'bx;
            assertCount++;
            if (txOut !== expBit) begin
                failCount++;
                $display("[TB] FAIL a5_even bit %0d: TX_OUT=%b expected %b", i, txOut, expBit);
            end
            assertCount++;
            if (busy !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL a5_even busy %0d: Busy=%b expected 1", i, busy);
            end
        end
        @(negedge clk);
        assertCount++;
        if (busy !== 1'b0 || txOut !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL a5_even end: Busy=%b TX_OUT=%b expected 0/1", busy, txOut);
        end
        assertCount++;
        if (parLoadCount - loads0 != 1) begin
            failCount++;
            $display("[TB] FAIL a5_even par_load count: %0d expected 1", parLoadCount - loads0);
        end
    endtask

    task automatic test_odd_parity;
        logic [7:0] words [2];
        words[0] = 8'h01;
        words[1] = 8'h00;
        for (int w = 0; w < 2; w++) begin
            applyStimulus(words[w], 1'b1, 1'b1);
            for (int i = 0; i < 11; i++) begin
                @(negedge clk);
                expBit = (expQ.size() > 0) ? expQ.pop_front() : 1'bx;
                assertCount++;
                if (txOut !== expBit) begin
                    failCount++;
                    $display("[TB] FAIL odd_%h bit %0d: TX_OUT=%b expected %b", words[w], i, txOut, expBit);
                end
            end
            @(negedge clk);
            assertCount++;
            if (busy !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL odd_%h end: Busy=%b expected 0", words[w], busy);
            end
        end
    endtask

    task automatic test_no_parity;
        applyStimulus(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            expBit = (expQ.size() > 0) ? expQ.pop_front() : 1'bx;
            assertCount++;
            if (txOut !== expBit || busy !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL ff_nopar bit %0d: TX_OUT=%b Busy=%b expected %b/1", i, txOut, busy, expBit);
            end
        end
        @(negedge clk);
        assertCount++;
        if (busy !== 1'b0 || txOut !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL ff_nopar end: Busy=%b TX_OUT=%b expected 0/1", busy, txOut);
        end
    endtask

    task automatic test_back_to_back;
        int loads0;
        loads0 = parLoadCount;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            expBit = (expQ.size() > 0) ? expQ.pop_front() : 1'bx;
            assertCount++;
            if (txOut !== expBit || busy !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL b2b_a5 bit %0d: TX_OUT=%b Busy=%b expected %b/1", i, txOut, busy, expBit);
            end
            if (i == 9) begin
                @(posedge clk);
                #1;
                pData     = 8'h3C;
                parEn     = 1'b1;
                parTyp    = 1'b0;
                dataValid = 1'b1;
                pushFrame(8'h3C, 1'b1, 1'b0);
            end
            if (i == 10) begin
                assertCount++;
                if (parLoad !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL b2b stop-cycle par_load: %b expected 1", parLoad);
                end
                @(posedge clk);
                #1;
                dataValid = 1'b0;
            end
        end
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            expBit = (expQ.size() > 0) ? expQ.pop_front() : 1'bx;
            assertCount++;
            if (txOut !== expBit || busy !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL b2b_3c bit %0d: TX_OUT=%b Busy=%b expected %b/1", i, txOut, busy, expBit);
            end
        end
        @(negedge clk);
        assertCount++;
        if (busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL b2b end: Busy=%b expected 0", busy);
        end
        assertCount++;
        if (parLoadCount - loads0 != 2) begin
            failCount++;
            $display("[TB] FAIL b2b par_load count: %0d expected 2", parLoadCount - loads0);
        end
    endtask

    task automatic test_ignore_busy;
        int loads0;
        loads0 = parLoadCount;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            expBit = (expQ.size() > 0) ? expQ.pop_front() : 1'bx;
            assertCount++;
            if (txOut !== expBit) begin
                failCount++;
                $display("[TB] FAIL ignore bit %0d: TX_OUT=%b expected %b", i, txOut, expBit);
            end
            if (i >= 3 && i <= 6) begin
                assertCount++;
                if (parLoad !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL ignore par_load cycle %0d: %b expected 0", i, parLoad);
                end
            end
            if (i == 2) begin
                @(posedge clk);
                #1;
                pData     = 8'h77;
                dataValid = 1'b1;
            end
            if (i == 6) begin
                @(posedge clk);
                #1;
                dataValid = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            assertCount++;
            if (txOut !== 1'b1 || busy !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL ignore idle %0d: TX_OUT=%b Busy=%b expected 1/0", i, txOut, busy);
            end
        end
        assertCount++;
        if (parLoadCount - loads0 != 1) begin
            failCount++;
            $display("[TB] FAIL ignore par_load count: %0d expected 1", parLoadCount - loads0);
        end
    endtask

    task automatic test_reset_mid_frame;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            expBit = (expQ.size() > 0) ? expQ.pop_front() : 1'bx;
            assertCount++;
            if (txOut !== expBit) begin
                failCount++;
                $display("[TB] FAIL rstmid bit %0d: TX_OUT=%b expected %b", i, txOut, expBit);
            end
        end
        #1;
        rst = 1'b0;
        #1;
        assertCount++;
        if (txOut !== 1'b1 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rstmid async: TX_OUT=%b Busy=%b expected 1/0", txOut, busy);
        end
        expQ.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        assertCount++;
        if (txOut !== 1'b1 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rstmid idle: TX_OUT=%b Busy=%b expected 1/0", txOut, busy);
        end
        applyStimulus(8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            expBit = (expQ.size() > 0) ? expQ.pop_front() : 1'bx;
            assertCount++;
            if (txOut !== expBit || busy !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL rstmid_5a bit %0d: TX_OUT=%b Busy=%b expected %b/1", i, txOut, busy, expBit);
            end
        end
        @(negedge clk);
        assertCount++;
        if (busy !== 1'b0 || txOut !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL rstmid_5a end: Busy=%b TX_OUT=%b expected 0/1", busy, txOut);
        end
    endtask

    // Test sequence
    initial begin
        assertCount  = 0;
        failCount    = 0;
        parLoadCount = 0;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
